// File: rtl/regwrite_arbiter_pkg.sv
// Shared widths, constants and helpers for the register-file write arbiter.
// Anything that needs NUM_REQ-dependent sizing should derive it through grant_w().
package regwrite_arbiter_pkg;

  localparam int DEFAULT_NUM_REQ    = 4;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 5;

  // Writes aimed at this index are accepted but never strobed into the file.
  localparam int ZERO_REG = 0;

  // Typical writeback sources in the default four-requester configuration.
  typedef enum logic [1:0] {
    SRC_ALU    = 2'd0,
    SRC_MULDIV = 2'd1,
    SRC_LOAD   = 2'd2,
    SRC_IO     = 2'd3
  } wb_source_e;

  // Width of a source index; never narrower than one bit.
  function automatic int grant_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/regwrite_arbiter_if.sv
// Bundles the writeback-source handshakes and the register-file write port.
// The master side drives requests and hold; the slave side is the arbiter.
interface regwrite_arbiter_if
  import regwrite_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = DEFAULT_NUM_REQ,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) ();

  localparam int GRANT_W = grant_w(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          rf_hold;
  logic                          rf_write_enable;
  logic [ADDR_WIDTH-1:0]         rf_write_addr;
  logic [DATA_WIDTH-1:0]         rf_write_data;
  logic [GRANT_W-1:0]            grant_id;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    output rf_hold,
    input  req_ready,
    input  rf_write_enable,
    input  rf_write_addr,
    input  rf_write_data,
    input  grant_id
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    input  rf_hold,
    output req_ready,
    output rf_write_enable,
    output rf_write_addr,
    output rf_write_data,
    output grant_id
  );

endinterface

// File: rtl/regwrite_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: scans from the rotate pointer upward,
// wrapping modulo NUM_REQ, and reports the first set request.
module rr_priority_picker
  import regwrite_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int GRANT_W = grant_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [GRANT_W-1:0] ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [GRANT_W-1:0] winner_o,
  output logic               any_grant_o
);

  int   scanIdx;
  logic found;

  // The pointer is always kept below NUM_REQ, so one subtraction wraps correctly
  // even when NUM_REQ is not a power of two.
  always_comb begin
    grant_o     = '0;
    winner_o    = '0;
    any_grant_o = 1'b0;
    scanIdx     = 0;
    found       = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scanIdx = int'(ptr_i) + k;
      if (scanIdx >= NUM_REQ) begin
        scanIdx = scanIdx - NUM_REQ;
      end
      if (!found && req_i[scanIdx]) begin
        found            = 1'b1;
        grant_o[scanIdx] = 1'b1;
        winner_o         = GRANT_W'(scanIdx);
      end
    end
    any_grant_o = found;
  end

endmodule

// File: rtl/regwrite_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NUM_REQ
// writeback sources; the accepted write is issued from a register one cycle later.
module regwrite_arbiter
  import regwrite_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = DEFAULT_NUM_REQ,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic              clock,
  input  logic              clear_n,
  regwrite_arbiter_if.slave bus
);

  localparam int GRANT_W = grant_w(NUM_REQ);

  logic [GRANT_W-1:0]    rrPtr_q,    rrPtr_d;
  logic                  wrEnable_q, wrEnable_d;
  logic [ADDR_WIDTH-1:0] wrAddr_q,   wrAddr_d;
  logic [DATA_WIDTH-1:0] wrData_q,   wrData_d;
  logic [GRANT_W-1:0]    grantId_q,  grantId_d;

  logic [NUM_REQ-1:0]    pickGrant;
  logic [GRANT_W-1:0]    pickWinner;
  logic                  pickAny;
  logic                  acceptGrant;
  logic [ADDR_WIDTH-1:0] selAddr;
  logic [DATA_WIDTH-1:0] selData;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .GRANT_W (GRANT_W)
  ) u_picker (
    .req_i       (bus.req_valid),
    .ptr_i       (rrPtr_q),
    .grant_o     (pickGrant),
    .winner_o    (pickWinner),
    .any_grant_o (pickAny)
  );

  // Hold and reset both suppress the ready pulse, so no source sees a transfer.
  assign acceptGrant   = pickAny & ~bus.rf_hold & clear_n;
  assign bus.req_ready = acceptGrant ? pickGrant : '0;

  always_comb begin
    selAddr = '0;
    selData = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pickWinner == GRANT_W'(i)) begin
        selAddr = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        selData = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Register-zero writes still update addr/data/id and advance the pointer,
  // they just never raise the strobe.
  always_comb begin
    rrPtr_d    = rrPtr_q;
    wrEnable_d = 1'b0;
    wrAddr_d   = wrAddr_q;
    wrData_d   = wrData_q;
    grantId_d  = grantId_q;
    if (acceptGrant) begin
      wrEnable_d = (selAddr != ADDR_WIDTH'(ZERO_REG));
      wrAddr_d   = selAddr;
      wrData_d   = selData;
      grantId_d  = pickWinner;
      rrPtr_d    = (pickWinner == GRANT_W'(NUM_REQ - 1)) ? '0 : pickWinner + GRANT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      rrPtr_q    <= '0;
      wrEnable_q <= 1'b0;
      wrAddr_q   <= '0;
      wrData_q   <= '0;
      grantId_q  <= '0;
    end else begin
      rrPtr_q    <= rrPtr_d;
      wrEnable_q <= wrEnable_d;
      wrAddr_q   <= wrAddr_d;
      wrData_q   <= wrData_d;
      grantId_q  <= grantId_d;
    end
  end

  assign bus.rf_write_enable = wrEnable_q;
  assign bus.rf_write_addr   = wrAddr_q;
  assign bus.rf_write_data   = wrData_q;
  assign bus.grant_id        = grantId_q;

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Directed bench for regwrite_arbiter: hand-computed grants and write beats,
// plus a small register-file model to confirm final contents after conflicts.
module tb_regwrite_arbiter;
  import regwrite_arbiter_pkg::*;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;

  logic clock = 1'b0;
  logic clear_n;
  int   vectors = 0;
  int   errors  = 0;

  logic [DATA_WIDTH-1:0] rfModel [32] = '{default: '0};

  always #5 clock = ~clock;

  regwrite_arbiter_if #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) bus ();

  regwrite_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) dut (
    .clock   (clock),
    .clear_n (clear_n),
    .bus     (bus.slave)
  );

  // The register file latches mid-cycle, well clear of the arbiter's edge.
  always @(negedge clock) begin
    if (bus.rf_write_enable) begin
      rfModel[bus.rf_write_addr] <= bus.rf_write_data;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkBeat(input string tag, input logic en, input logic [ADDR_WIDTH-1:0] addr,
                           input logic [DATA_WIDTH-1:0] data, input logic [1:0] gid);
    checkOutput({tag, ".we"},   64'(bus.rf_write_enable), 64'(en));
    checkOutput({tag, ".addr"}, 64'(bus.rf_write_addr),   64'(addr));
    checkOutput({tag, ".data"}, 64'(bus.rf_write_data),   64'(data));
    checkOutput({tag, ".gid"},  64'(bus.grant_id),        64'(gid));
  endtask

  task automatic setSource(input int idx, input logic [ADDR_WIDTH-1:0] addr, input logic [DATA_WIDTH-1:0] data);
    bus.req_addr[idx*ADDR_WIDTH +: ADDR_WIDTH] = addr;
    bus.req_data[idx*DATA_WIDTH +: DATA_WIDTH] = data;
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] valid, input logic hold);
    bus.req_valid = valid;
    bus.rf_hold   = hold;
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    clear_n      = 1'b0;
    bus.req_addr = '0;
    bus.req_data = '0;
    applyStimulus(4'b1111, 1'b0);
    #3;
    checkOutput("reset.ready", 64'(bus.req_ready), 64'h0);
    checkBeat("reset", 1'b0, 5'd0, 32'h0, 2'd0);
    applyStimulus(4'b0000, 1'b0);
    #20;
    clear_n = 1'b1;
    nextCycle();

    // Single request from source 0
    setSource(0, 5'd7, 32'hDEADBEEF);
    applyStimulus(4'b0001, 1'b0);
    #1 checkOutput("single.ready", 64'(bus.req_ready), 64'h1);
    nextCycle();
    checkBeat("single", 1'b1, 5'd7, 32'hDEADBEEF, 2'd0);
    applyStimulus(4'b0000, 1'b0);
    #1 checkOutput("idle.ready", 64'(bus.req_ready), 64'h0);
    nextCycle();
    checkBeat("idle", 1'b0, 5'd7, 32'hDEADBEEF, 2'd0);

    // Pointer is 1; a lone source 3 grant wraps it back to 0
    setSource(3, 5'd3, 32'h3);
    applyStimulus(4'b1000, 1'b0);
    #1 checkOutput("wrap.ready", 64'(bus.req_ready), 64'h8);
    nextCycle();
    checkBeat("wrap", 1'b1, 5'd3, 32'h3, 2'd3);

    // All four continuously valid: strict rotation, one write per cycle
    for (int i = 0; i < NUM_REQ; i++) begin
      setSource(i, 5'(16 + i), 32'h100 + 32'(i));
    end
    applyStimulus(4'b1111, 1'b0);
    for (int k = 0; k < 8; k++) begin
      #1 checkOutput($sformatf("rr%0d.ready", k), 64'(bus.req_ready), 64'(4'b0001 << (k % 4)));
      nextCycle();
      checkBeat($sformatf("rr%0d", k), 1'b1, 5'(16 + k % 4), 32'h100 + 32'(k % 4), 2'(k % 4));
    end
    applyStimulus(4'b0000, 1'b0);

    // Register zero: accepted, pointer moves, no strobe
    setSource(0, 5'd0, 32'h12345678);
    applyStimulus(4'b0001, 1'b0);
    #1 checkOutput("zero.ready", 64'(bus.req_ready), 64'h1);
    nextCycle();
    checkBeat("zero", 1'b0, 5'd0, 32'h12345678, 2'd0);
    setSource(3, 5'd3, 32'h33);
    applyStimulus(4'b1001, 1'b0);
    #1 checkOutput("zeroadv.ready", 64'(bus.req_ready), 64'h8);
    nextCycle();
    checkBeat("zeroadv", 1'b1, 5'd3, 32'h33, 2'd3);

    // Hold freezes grants; release resumes at source 1 then 2
    setSource(1, 5'd1, 32'h11);
    setSource(2, 5'd2, 32'h22);
    applyStimulus(4'b0110, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1 checkOutput($sformatf("hold%0d.ready", k), 64'(bus.req_ready), 64'h0);
      nextCycle();
      checkOutput($sformatf("hold%0d.we", k), 64'(bus.rf_write_enable), 64'h0);
    end
    applyStimulus(4'b0110, 1'b0);
    #1 checkOutput("rel1.ready", 64'(bus.req_ready), 64'h2);
    nextCycle();
    checkBeat("rel1", 1'b1, 5'd1, 32'h11, 2'd1);
    applyStimulus(4'b0100, 1'b0);
    #1 checkOutput("rel2.ready", 64'(bus.req_ready), 64'h4);
    nextCycle();
    checkBeat("rel2", 1'b1, 5'd2, 32'h22, 2'd2);

    // Same-address conflict from pointer 3: 0xB lands first, 0xA last
    setSource(2, 5'd9, 32'hA);
    setSource(3, 5'd9, 32'hB);
    applyStimulus(4'b1100, 1'b0);
    #1 checkOutput("conf1.ready", 64'(bus.req_ready), 64'h8);
    nextCycle();
    checkBeat("conf1", 1'b1, 5'd9, 32'hB, 2'd3);
    applyStimulus(4'b0100, 1'b0);
    #1 checkOutput("conf2.ready", 64'(bus.req_ready), 64'h4);
    nextCycle();
    checkBeat("conf2", 1'b1, 5'd9, 32'hA, 2'd2);
    applyStimulus(4'b0000, 1'b0);
    nextCycle();
    checkOutput("rf.r9", 64'(rfModel[9]), 64'hA);
    checkOutput("rf.r0", 64'(rfModel[0]), 64'h0);

    // Reset right after a grant drops the registered write
    setSource(0, 5'd5, 32'h55);
    applyStimulus(4'b0001, 1'b0);
    #1 checkOutput("midrst.ready", 64'(bus.req_ready), 64'h1);
    nextCycle();
    checkBeat("midrst.pre", 1'b1, 5'd5, 32'h55, 2'd0);
    applyStimulus(4'b0000, 1'b0);
    clear_n = 1'b0;
    #1;
    checkBeat("midrst.in", 1'b0, 5'd0, 32'h0, 2'd0);
    nextCycle();
    nextCycle();
    checkOutput("midrst.rf5", 64'(rfModel[5]), 64'h0);
    clear_n = 1'b1;
    applyStimulus(4'b1111, 1'b0);
    #1 checkOutput("midrst.ptr", 64'(bus.req_ready), 64'h1);
    nextCycle();
    applyStimulus(4'b0000, 1'b0);
    checkBeat("midrst.post", 1'b1, 5'd5, 32'h55, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
